// File: rtl/partsel_byte_streamer.sv
// Serialises one wide word into byte-wide indexed part-selects (+: or -:) over a
// ready/valid stream, one slice per output handshake.
module partsel_byte_streamer #(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned BYTE_W = 8,
    parameter int unsigned OFS_W  = 8,
    parameter int unsigned CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [OFS_W-1:0]  in_base,
    input  logic [CNT_W-1:0]  in_count,
    input  logic              in_desc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] out_byte,
    output logic              out_last,
    output logic              busy
);

    // Two guard bits keep the pointer's overshoot above DATA_W and below 0 distinguishable.
    localparam int unsigned PTR_W = OFS_W + 2;
    localparam int unsigned BI_W  = $clog2(BYTE_W);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                desc_q, desc_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]    rem_q, rem_d;
    logic [BYTE_W-1:0]   slice_c;
    logic                streaming_c;

    assign streaming_c = (state_q == STREAM);
    assign in_ready    = (state_q == IDLE) && !rst;
    assign out_valid   = streaming_c;
    assign busy        = streaming_c;
    assign out_last    = streaming_c && (rem_q == CNT_W'(1));
    assign out_byte    = streaming_c ? slice_c : '0;

    // Bit gather; positions with either guard bit set lie outside the word and read 0.
    always_comb begin
        slice_c = '0;
        for (int k = 0; k < BYTE_W; k++) begin
            logic [PTR_W-1:0] idx;
            idx = desc_q ? (ptr_q - PTR_W'(k)) : (ptr_q + PTR_W'(k));
            if (idx[PTR_W-1:OFS_W] == '0) begin
                slice_c[BI_W'(desc_q ? (BYTE_W - 1 - k) : k)] = data_q[idx[OFS_W-1:0]];
            end
        end
    end

    // Next-state: capture on accept, step pointer and count on each output handshake.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        desc_d  = desc_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    data_d = in_data;
                    desc_d = in_desc;
                    ptr_d  = PTR_W'(in_base);
                    rem_d  = in_count;
                    if (in_count != '0) begin
                        state_d = STREAM;
                    end
                end
            end
            STREAM: begin
                if (out_ready) begin
                    ptr_d = desc_q ? (ptr_q - PTR_W'(BYTE_W)) : (ptr_q + PTR_W'(BYTE_W));
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            desc_q  <= 1'b0;
            ptr_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            desc_q  <= desc_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
        end
    end

endmodule

// File: tb/tb_partsel_byte_streamer.sv
// Directed bench for partsel_byte_streamer: ascending/descending slices, zero fill,
// backpressure, zero-count requests and mid-stream reset.
module tb_partsel_byte_streamer;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] in_data;
    logic [7:0]   in_base;
    logic [5:0]   in_count;
    logic         in_desc;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_byte;
    logic         out_last;
    logic         busy;

    int total = 0;
    int bad   = 0;

    logic [255:0] ramp;
    logic [255:0] ones;

    partsel_byte_streamer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_base   (in_base),
        .in_count  (in_count),
        .in_desc   (in_desc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_byte  (out_byte),
        .out_last  (out_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one request while idle; returns just after the accepting edge.
    task automatic req(input logic [255:0] d, input logic [7:0] b,
                       input logic [5:0] c, input logic ds);
        @(negedge clk);
        chk("in_ready_before_req", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_base  = b;
        in_count = c;
        in_desc  = ds;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    // Expect n bytes back-to-back (out_ready high), then the idle bubble.
    task automatic expect_bytes(input string tag, input int n, input logic [31:0] exp);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk({tag, "_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_byte"},  32'(out_byte),  32'(exp[8*i +: 8]));
            chk({tag, "_last"},  32'(out_last),  (i == n - 1) ? 32'd1 : 32'd0);
            chk({tag, "_busy"},  32'(busy),      32'd1);
        end
        @(negedge clk);
        chk({tag, "_done_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_done_ready"}, 32'(in_ready),  32'd1);
        chk({tag, "_done_busy"},  32'(busy),      32'd0);
    endtask

    initial begin
        for (int k = 0; k < 32; k++) ramp[8*k +: 8] = 8'(k);
        ones      = '1;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_base   = '0;
        in_count  = '0;
        in_desc   = 1'b0;
        out_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_out_byte", 32'(out_byte), 32'd0);
        chk("reset_out_last", 32'(out_last), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_in_ready", 32'(in_ready), 32'd1);
        chk("post_reset_out_valid", 32'(out_valid), 32'd0);

        // Ascending walk over the ramp word.
        req(ramp, 8'd8, 6'd3, 1'b0);
        expect_bytes("asc_walk", 3, 32'h0003_0201);

        // Descending, unaligned base.
        req(ramp, 8'd15, 6'd2, 1'b1);
        expect_bytes("desc_15", 2, 32'h0000_0001);
        req(ramp, 8'd30, 6'd1, 1'b1);
        expect_bytes("desc_30", 1, 32'h0000_0006);

        // Zero fill beyond either end of the word.
        req(ones, 8'd252, 6'd2, 1'b0);
        expect_bytes("asc_top_fill", 2, 32'h0000_000F);
        req(ones, 8'd3, 6'd1, 1'b1);
        expect_bytes("desc_bot_fill", 1, 32'h0000_00F0);

        // Backpressure: three stalled cycles with byte and last held.
        out_ready = 1'b0;
        req(ramp, 8'd0, 6'd2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_byte", 32'(out_byte), 32'd0);
            chk("stall_last", 32'(out_last), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        expect_bytes("after_stall", 2, 32'h0000_0100);

        // Zero-count request is swallowed.
        req(ramp, 8'd16, 6'd0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("zero_cnt_valid", 32'(out_valid), 32'd0);
            chk("zero_cnt_ready", 32'(in_ready), 32'd1);
            chk("zero_cnt_busy", 32'(busy), 32'd0);
        end

        // Reset after the second byte of a five-byte request.
        req(ramp, 8'd0, 6'd5, 1'b0);
        @(negedge clk);
        chk("rst_req_b0", 32'(out_byte), 32'h00);
        @(negedge clk);
        chk("rst_req_b1", 32'(out_byte), 32'h01);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_valid", 32'(out_valid), 32'd0);
            chk("abort_busy", 32'(busy), 32'd0);
            chk("abort_ready", 32'(in_ready), 32'd1);
            chk("abort_byte", 32'(out_byte), 32'd0);
        end

        // Block is usable again after the abort.
        req(ramp, 8'd40, 6'd2, 1'b0);
        expect_bytes("post_abort", 2, 32'h0000_0605);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/partsel_byte_streamer.md
# partsel_byte_streamer

Sequential byte extractor that sits directly downstream of a wide part-select data register. It accepts one 256-bit word plus a starting bit offset, byte count and direction. It then emits one 8-bit indexed part-select per handshake over a ready/valid stream: `+:` semantics when ascending, `-:` when descending. It is the serialising consumer of the wide registers that feed byte-slicing logic, and lets gate-level part-select results be checked one byte at a time.

## Interface
- `DATA_W`, 256: width of the captured word.
- `BYTE_W`, 8: width of each emitted slice.
- `OFS_W`, 8: width of the start offset (log2 `DATA_W`).
- `CNT_W`, 6: width of the byte count; supports 0..32.

Ports (`name`, direction, width, meaning):
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: request valid.
- `in_ready`, output, 1: block can accept a request.
- `in_data`, input, `DATA_W`: word to slice.
- `in_base`, input, `OFS_W`: starting bit position.
- `in_count`, input, `CNT_W`: number of bytes to emit.
- `in_desc`, input, 1: 0 selects `+:`, 1 selects `-:`.
- `out_valid`, output, 1: `out_byte` valid.
- `out_ready`, input, 1: consumer accepts `out_byte`.
- `out_byte`, output, `BYTE_W`: current slice.
- `out_last`, output, 1: current slice is the final one of the request.
- `busy`, output, 1: a request is in progress.

## Operation
- States: IDLE and STREAM.
- `in_ready` = (state == IDLE) && !`rst`.
- Accept = `in_valid` && `in_ready`. On accept, the block registers `in_data`, `in_desc`, `ptr` = `in_base` (10-bit signed internal) and `rem` = `in_count`.
  - If `in_count` != 0, next state is STREAM.
  - If `in_count` == 0, the request is consumed with no output and the state stays IDLE.
- In STREAM:
  - `out_valid` = 1 and `busy` = 1.
  - `out_last` = (`rem` == 1).
- Slice rule, ascending: `out_byte[k]` = `data[ptr+k]` for k = 0..7.
- Slice rule, descending: `out_byte[7-k]` = `data[ptr-k]`, so `out_byte[7]` = `data[ptr]`.
- Any bit position outside 0..`DATA_W`-1 reads 0. There is no wrap-around.
- On an output handshake (`out_valid` && `out_ready`):
  - `ptr` += 8 when ascending, `ptr` -= 8 when descending. The 10-bit `ptr` never wraps for legal inputs.
  - `rem` -= 1.
  - If `out_last` was 1, next state is IDLE.
- `in_data`, `in_base`, `in_count` and `in_desc` are ignored while in STREAM.
- Reset values: state IDLE, `out_valid` 0, `out_last` 0, `busy` 0, `out_byte` 0, `in_ready` 0 while `rst` is high and 1 on the first cycle after.
- Reset mid-stream aborts the request immediately. No further bytes are emitted and the captured data is discarded.

## Timing
- Request accepted at edge N: the first `out_valid` is seen in cycle N+1 (one-cycle latency).
- Throughput is one byte per cycle while `out_ready` is held high.
- After the last handshake at edge M, the block is IDLE and `in_ready` is 1 in cycle M+1. This gives a one-cycle bubble between requests; there is no accept in the same cycle as the last handshake.
- While `out_valid` && !`out_ready`, `out_byte` and `out_last` are held stable. They are driven only from registered state.
- `out_byte` may be combinational from `data` and `ptr`, but it must not depend on `out_ready`.

## Test plan
- Ascending walk: `in_data` with byte k = k (`data[8k+7:8k]` = k), `in_base`=8, count=3, desc=0, `out_ready`=1.
  - Expected: 0x01, 0x02, 0x03 in consecutive cycles.
  - `out_last` high only with 0x03.
  - `in_ready` back to 1 one cycle later.
- Descending with unaligned base: same data, `in_base`=15, count=2, desc=1.
  - Expected: 0x01 (`data[15:8]`), then 0x00 (`data[7:0]`).
  - With `in_base`=30, count=1: output is `data[30:23]` = 0x06 (bits from bytes 3 and 2: 0x03<<1 | 0x02>>7).
- Out-of-range zero fill, all-ones data:
  - asc base=252, count=2: expected 0x0F, then 0x00.
  - desc base=3, count=1: expected 0xF0.
- Backpressure: asc base=0, count=2, `out_ready` low for 3 cycles after `out_valid` rises.
  - `out_byte` holds 0x00 and `out_last` holds 0 throughout.
  - When ready rises, 0x00 then 0x01 are emitted.
- Zero count and reset: count=0 accepted, then `out_valid` stays 0 and `in_ready` stays 1.
  - Separately, assert `rst` for one cycle after the 2nd byte of a count=5 request.
  - Next cycle: `out_valid`=0, `busy`=0, `in_ready`=1, and no further bytes appear.
